winner_scanner: RTL and testbench

Sequential, parametrised successor to the combinational tic-tac-toe winner detector. Snapshots an N×N board on a start pulse, then examines one line per cycle (rows, columns, two diagonals) and reports the winner, the index of the winning line, or a draw. Sits between the board-state register and the game-control FSM. Any board size can be handled with one comparator slice.

---
 rtl/winner_scanner.sv | 150 +++++++++++++++
 tb/tb_winner_scanner.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/winner_scanner.sv
// Sequential N x N winner detector: snapshots the board on start, then tests one
// line per cycle (rows, columns, main diagonal, anti-diagonal) and reports a win or a draw.
module winner_scanner #(
  parameter int N = 3,
  localparam int LW = $clog2(2*N+2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2*N*N-1:0]  board,
  output logic              busy,
  output logic              done,
  output logic              win,
  output logic [1:0]        who,
  output logic [LW-1:0]     line,
  output logic              draw
);

  localparam int NB   = 2*N*N;
  localparam int LAST = 2*N+1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q, state_d;
  logic [NB-1:0]   snap_q, snap_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            win_q, win_d;
  logic [1:0]      who_q, who_d;
  logic [LW-1:0]   line_q, line_d;
  logic            draw_q, draw_d;

  logic [1:0]      first_cell;
  logic            line_win;
  logic            board_full;

  // Maps (line index, position along the line) to the cell value in the snapshot.
  function automatic logic [1:0] line_cell(input logic [NB-1:0] b, input logic [LW-1:0] k,
                                           input int j);
    int ki, r, c;
    ki = int'(k);
    if (ki < N) begin
      r = ki; c = j;
    end else if (ki < 2*N) begin
      r = j; c = ki - N;
    end else if (ki == 2*N) begin
      r = j; c = j;
    end else begin
      r = j; c = N - 1 - j;
    end
    return b[2*(r*N+c) +: 2];
  endfunction

  always_comb begin
    first_cell = line_cell(snap_q, idx_q, 0);
    line_win   = (first_cell == 2'b01) || (first_cell == 2'b10);
    for (int j = 1; j < N; j++) begin
      if (line_cell(snap_q, idx_q, j) != first_cell) line_win = 1'b0;
    end
    // A cell is occupied exactly when its two bits differ (01 or 10).
    board_full = 1'b1;
    for (int i = 0; i < N*N; i++) begin
      if (snap_q[2*i] == snap_q[2*i+1]) board_full = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    win_d   = win_q;
    who_d   = who_q;
    line_d  = line_q;
    draw_d  = draw_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SCAN;
          snap_d  = board;
          idx_d   = '0;
          busy_d  = 1'b1;
          win_d   = 1'b0;
          who_d   = 2'b00;
          line_d  = '0;
          draw_d  = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      SCAN: begin
        busy_d = 1'b1;
        if (line_win) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          win_d   = 1'b1;
          who_d   = first_cell;
          line_d  = idx_q;
        end else if (idx_q == LAST[LW-1:0]) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          draw_d  = board_full;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      win_q   <= 1'b0;
      who_q   <= 2'b00;
      line_q  <= '0;
      draw_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      win_q   <= win_d;
      who_q   <= who_d;
      line_q  <= line_d;
      draw_q  <= draw_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign win  = win_q;
  assign who  = who_q;
  assign line = line_q;
  assign draw = draw_q;

endmodule

// File: tb/tb_winner_scanner.sv
// Self-checking bench for winner_scanner at N=3, 4 and 5, compared against a
// line-counting reference model of the game rules.
module tb_winner_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [49:0] board_in;

  logic busy3, done3, win3, draw3;
  logic busy4, done4, win4, draw4;
  logic busy5, done5, win5, draw5;
  logic [1:0] who3, who4, who5;
  logic [2:0] line3;
  logic [3:0] line4, line5;

  int checks = 0;
  int errors = 0;

  logic       obs_busy, obs_done, obs_win, obs_draw;
  logic [1:0] obs_who;
  logic [7:0] obs_line;

  logic [1:0] draw_tab [9] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};

  winner_scanner #(.N(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .board(board_in[17:0]),
    .busy(busy3), .done(done3), .win(win3), .who(who3), .line(line3), .draw(draw3)
  );
  winner_scanner #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .board(board_in[31:0]),
    .busy(busy4), .done(done4), .win(win4), .who(who4), .line(line4), .draw(draw4)
  );
  winner_scanner #(.N(5)) dut5 (
    .clk(clk), .reset(reset), .start(start), .board(board_in[49:0]),
    .busy(busy5), .done(done5), .win(win5), .who(who5), .line(line5), .draw(draw5)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int mk_pack(input logic b, input logic d, input logic w,
                                 input logic [1:0] wh, input logic [7:0] ln, input logic dr);
    return {18'd0, b, d, w, wh, ln, dr};
  endfunction

  function automatic int obs_pack();
    return mk_pack(obs_busy, obs_done, obs_win, obs_who, obs_line, obs_draw);
  endfunction

  task automatic sample(input int sel);
    case (sel)
      3: begin
        obs_busy = busy3; obs_done = done3; obs_win = win3;
        obs_who = who3; obs_line = {5'd0, line3}; obs_draw = draw3;
      end
      4: begin
        obs_busy = busy4; obs_done = done4; obs_win = win4;
        obs_who = who4; obs_line = {4'd0, line4}; obs_draw = draw4;
      end
      default: begin
        obs_busy = busy5; obs_done = done5; obs_win = win5;
        obs_who = who5; obs_line = {4'd0, line5}; obs_draw = draw5;
      end
    endcase
  endtask

  function automatic logic [1:0] cell_at(input logic [49:0] b, input int n, input int r, input int c);
    return b[2*(r*n+c) +: 2];
  endfunction

  function automatic logic [49:0] put_cell(input logic [49:0] b, input int n, input int r,
                                           input int c, input logic [1:0] v);
    b[2*(r*n+c) +: 2] = v;
    return b;
  endfunction

  // Coordinates of the j-th cell of line k in the rows/columns/diagonals numbering.
  function automatic void line_rc(input int n, input int k, input int j, output int r, output int c);
    if (k < n) begin
      r = k; c = j;
    end else if (k < 2*n) begin
      r = j; c = k - n;
    end else if (k == 2*n) begin
      r = j; c = j;
    end else begin
      r = j; c = n - 1 - j;
    end
  endfunction

  function automatic logic [49:0] line_board(input int n, input int k, input logic [1:0] v);
    logic [49:0] b;
    int r, c;
    b = '0;
    for (int j = 0; j < n; j++) begin
      line_rc(n, k, j, r, c);
      b = put_cell(b, n, r, c, v);
    end
    return b;
  endfunction

  function automatic logic [49:0] rand_board(input int n);
    logic [49:0] b;
    int v;
    b = '0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        v = $urandom_range(0, 9);
        b = put_cell(b, n, r, c, (v < 4) ? 2'b01 : (v < 8) ? 2'b10 : (v == 8) ? 2'b00 : 2'b11);
      end
    end
    return b;
  endfunction

  // Counts X and O marks per line in index order; a line is won when one player holds all n cells.
  function automatic void ref_model(input logic [49:0] b, input int n, output logic w,
                                    output logic [1:0] wh, output logic [7:0] ln,
                                    output logic dr, output int lat);
    int nx, no, filled, r, c;
    logic [1:0] v;
    w = 1'b0; wh = 2'b00; ln = 8'd0; lat = 2*n + 2;
    for (int k = 0; k < 2*n+2 && !w; k++) begin
      nx = 0; no = 0;
      for (int j = 0; j < n; j++) begin
        line_rc(n, k, j, r, c);
        v = cell_at(b, n, r, c);
        if (v == 2'b01) nx++;
        if (v == 2'b10) no++;
      end
      if (nx == n || no == n) begin
        w   = 1'b1;
        wh  = (nx == n) ? 2'b01 : 2'b10;
        ln  = 8'(k);
        lat = k + 1;
      end
    end
    filled = 0;
    for (int r2 = 0; r2 < n; r2++)
      for (int c2 = 0; c2 < n; c2++) begin
        v = cell_at(b, n, r2, c2);
        if (v == 2'b01 || v == 2'b10) filled++;
      end
    dr = !w && (filled == n*n);
  endfunction

  task automatic settle();
    int c;
    c = 0;
    while ((busy3 || busy4 || busy5) && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput("settle_timeout", (c >= 40) ? 1 : 0, 0);
  endtask

  // One scan on DUT "sel"; optionally changes the board and pulses start mid-scan.
  task automatic applyStimulus(input int sel, input logic [49:0] b, input logic [49:0] b_mid,
                               input int mid_cycle, input string tag);
    logic w, dr;
    logic [1:0] wh;
    logic [7:0] ln;
    int lat, cycles;
    ref_model(b, sel, w, wh, ln, dr, lat);
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sample(sel);
    checkOutput({tag, "_accept"}, obs_pack(), mk_pack(1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0));
    cycles = 0;
    while (!obs_done && cycles < 40) begin
      if (cycles == mid_cycle) begin
        board_in = b_mid;
        start    = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
      sample(sel);
    end
    checkOutput({tag, "_latency"}, cycles, lat);
    checkOutput({tag, "_result"}, obs_pack(), mk_pack(1'b0, 1'b1, w, wh, ln, dr));
    @(posedge clk); #1;
    sample(sel);
    checkOutput({tag, "_hold"}, obs_pack(), mk_pack(1'b0, 1'b0, w, wh, ln, dr));
    settle();
  endtask

  initial begin
    logic [49:0] b;
    int cycles;
    logic seen;

    reset    = 1'b1;
    start    = 1'b0;
    board_in = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 3; s <= 5; s++) begin
      sample(s);
      checkOutput($sformatf("reset_state_n%0d", s), obs_pack(), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      sample(3);
      checkOutput($sformatf("idle_hold_%0d", i), obs_pack(), 0);
    end

    for (int k = 0; k < 8; k++)
      applyStimulus(3, line_board(3, k, (k == 0) ? 2'b01 : 2'b10), '0, -1, $sformatf("line%0d", k));

    b = '0;
    for (int i = 0; i < 9; i++) b = put_cell(b, 3, i / 3, i % 3, draw_tab[i]);
    applyStimulus(3, b, '0, -1, "draw_full");
    b = put_cell(b, 3, 1, 1, 2'b00);
    applyStimulus(3, b, '0, -1, "draw_centre_empty");

    applyStimulus(3, line_board(3, 0, 2'b11), '0, -1, "row_invalid");
    applyStimulus(3, line_board(3, 0, 2'b01) | line_board(3, 3, 2'b01), '0, -1, "double_win");
    applyStimulus(3, '0, line_board(3, 0, 2'b01), 2, "mid_change");

    // Back-to-back: start held high through the DONE cycle.
    @(negedge clk);
    board_in = line_board(3, 2, 2'b01);
    start    = 1'b1;
    @(posedge clk); #1;
    cycles = 0;
    sample(3);
    while (!obs_done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      sample(3);
    end
    checkOutput("b2b_first_latency", cycles, 3);
    checkOutput("b2b_first_result", obs_pack(), mk_pack(1'b0, 1'b1, 1'b1, 2'b01, 8'd2, 1'b0));
    board_in = line_board(3, 0, 2'b10);
    @(posedge clk); #1;
    sample(3);
    checkOutput("b2b_accept_clean", obs_pack(), mk_pack(1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0));
    start  = 1'b0;
    cycles = 0;
    while (!obs_done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      sample(3);
    end
    checkOutput("b2b_second_latency", cycles, 1);
    checkOutput("b2b_second_result", obs_pack(), mk_pack(1'b0, 1'b1, 1'b1, 2'b10, 8'd0, 1'b0));
    settle();

    // Reset in the middle of a scan aborts it without a done pulse.
    @(negedge clk);
    board_in = '0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    sample(3);
    checkOutput("reset_abort", obs_pack(), 0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done3) seen = 1'b1;
    end
    checkOutput("no_done_after_abort", int'(seen), 0);
    applyStimulus(3, line_board(3, 5, 2'b01), '0, -1, "after_reset");

    applyStimulus(4, line_board(4, 9, 2'b01), '0, -1, "n4_anti_diag");
    applyStimulus(5, line_board(5, 11, 2'b10), '0, -1, "n5_anti_diag");

    for (int i = 0; i < 16; i++) applyStimulus(3, rand_board(3), '0, -1, $sformatf("rand3_%0d", i));
    for (int i = 0; i < 5; i++) applyStimulus(4, rand_board(4), '0, -1, $sformatf("rand4_%0d", i));
    for (int i = 0; i < 5; i++) applyStimulus(5, rand_board(5), '0, -1, $sformatf("rand5_%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
